// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch unit placed in front of the IF/ID register. A
// request/response fetch engine fills a DEPTH-entry in-order FIFO. The FIFO
// hides variable instruction-memory latency. The ID-stage stall (ifidWrite)
// acts as dequeue back-pressure. A branch/jump redirect from ID does three
// things: it flushes the FIFO, it restarts fetch at the target, and it arranges
// for every response still in flight to be dropped when it arrives.
//
// Parameters
//   DEPTH            FIFO entries (power of 2, >= 2)
//   MAX_OUTSTANDING  max accepted-but-unanswered memory requests (>= 1)
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   redirect, redirect_pc    taken branch/jump from ID and its word-aligned target
//   imem_req, imem_addr      fetch request and its address
//   imem_gnt                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata  in-order response and its instruction word
//   deq_ready                IF/ID can load (ifidWrite)
//   inst_valid               FIFO head valid
//   inst_out, pc4_out        registered head instruction and its PC+4
//
// Optional build macro
//   FETCH_PERF_EN  adds two wrapping 32-bit counters:
//                  perf_fetched counts instructions pushed (discarded responses excluded).
//                  perf_bubble counts cycles in which deq_ready is set and inst_valid is clear.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        deq_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // Width of the credit sum count + outstanding: the wider operand plus one carry bit.
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [31:0]   instMem [DEPTH];
  logic [31:0]   pc4Mem  [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;

  logic          accept;
  logic          pushEn;
  logic          popEn;
  logic          headFromPush;
  logic [SW-1:0] creditUsed;
  logic [CW-1:0] countNext;
  logic [AW-1:0] rdPtrNext;

  assign imem_addr  = fetchPc;
  assign inst_valid = (count != '0);

  always_comb begin
    // NOTE: every signal driven here gets a default before any condition, so no
    // path can leave one unassigned and infer a latch.
    imem_req     = 1'b0;
    creditUsed   = SW'(count) + SW'(outstanding);
    // Every in-flight request owns a FIFO slot, so a granted response always
    // has somewhere to land.
    if (!redirect && (outstanding < OW'(MAX_OUTSTANDING)) && (creditUsed < SW'(DEPTH))) begin
      imem_req = 1'b1;
    end
    accept       = imem_req && imem_gnt;
    pushEn       = imem_rvalid && !redirect && (discard == '0);
    popEn        = inst_valid && deq_ready && !redirect;
    countNext    = count + CW'(pushEn) - CW'(popEn);
    rdPtrNext    = rdPtr + AW'(popEn);
    // If the FIFO holds nothing after the pop, the word arriving now becomes
    // the new head.
    headFromPush = pushEn && (count == CW'(popEn));
  end

  // Fetch engine, response accounting, and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated only with non-blocking assignments. Every
    // right-hand side in this block then sees the pre-edge value, whatever the
    // statement order.
    if (rst) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetchPc     <= redirect_pc;
      respPc      <= redirect_pc;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      // imem_req is low here, so there is no accept. Any response arriving in
      // this cycle is already dropped. Everything still in flight is stale.
      outstanding <= outstanding - OW'(imem_rvalid);
      discard     <= outstanding - OW'(imem_rvalid);
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(imem_rvalid);
      count       <= countNext;
      rdPtr       <= rdPtrNext;
      if (accept) begin
        fetchPc <= fetchPc + 32'd4;
      end
      if (imem_rvalid && (discard != '0)) begin
        discard <= discard - OW'(1);
      end
      if (pushEn) begin
        wrPtr  <= wrPtr + AW'(1);
        respPc <= respPc + 32'd4;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this storage array is cleared on reset on purpose. The head
    // registers never expose an unwritten entry, but the block's contract is
    // that all storage reads back zero after reset.
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instMem[i] <= '0;
        pc4Mem[i]  <= '0;
      end
    end else if (pushEn) begin
      instMem[wrPtr] <= imem_rdata;
      pc4Mem[wrPtr]  <= respPc + 32'd4;
    end
  end

  // Registered head. These registers keep their last value when the FIFO
  // drains or is flushed, and the consumer ignores them while inst_valid is
  // low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out <= '0;
      pc4_out  <= '0;
    end else if (headFromPush) begin
      inst_out <= imem_rdata;
      pc4_out  <= respPc + 32'd4;
    end else if (popEn && (countNext != '0)) begin
      inst_out <= instMem[rdPtrNext];
      pc4_out  <= pc4Mem[rdPtrNext];
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      if (pushEn) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (deq_ready && !inst_valid) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Testbench for fetch_queue. Its reference model works at the level of the
// instruction stream:
//   - every accepted fetch must carry the next sequential PC since the last
//     redirect; that PC is pushed on an expected-stream queue;
//   - a redirect empties the expected-stream queue and marks every in-flight
//     memory request stale;
//   - a monitor compares the DUT head against the queue front and pops the
//     queue on each dequeue.
// A behavioural memory returns responses in order, each after a random
// latency. It answers with dataOf(addr).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        deq_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  fetch_queue #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .deq_ready(deq_ready),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc4_out(pc4_out)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mem_req_t;

  mem_req_t    memQ[$];     // accepted requests awaiting a response
  logic [31:0] expQ[$];     // expected PCs: in the FIFO or in flight (not stale)
  logic [31:0] fetchPcModel = RESET_PC;
  logic [31:0] dataKey = '0;
  logic [31:0] lastPopPc4 = '0;
  logic [31:0] lastPopInst = '0;
  int unsigned cyc = 0;
  int unsigned acceptCount = 0;
  int unsigned popCount = 0;
  int unsigned fetchedModel = 0;
  int unsigned bubbleModel = 0;
  int          gntPct = 100;
  int          latMin = 1;
  int          latMax = 1;
  int          nonStale;
  int          fifoCount;
  bit          expReq;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return a ^ dataKey;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and request checker. It samples at the falling edge, when
  // the values seen are those that will take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      memQ.delete();
      expQ.delete();
      fetchPcModel = RESET_PC;
      fetchedModel = 0;
      bubbleModel  = 0;
    end else begin
      nonStale = 0;
      foreach (memQ[i]) if (!memQ[i].stale) nonStale++;
      fifoCount = expQ.size() - nonStale;
      check("inst_valid_vs_model", inst_valid, (fifoCount > 0));
      expReq = !redirect && (memQ.size() < MAXO) && (fifoCount + memQ.size() < DEPTH);
      check("imem_req_credit", imem_req, expReq);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, fetchedModel);
      check("perf_bubble", perf_bubble, bubbleModel);
`endif
      if (deq_ready && fifoCount == 0) bubbleModel++;
      if (redirect) begin
        check("redirect_pc_aligned", redirect_pc[1:0], 2'b00);
        foreach (memQ[i]) memQ[i].stale = 1'b1;
        expQ.delete();
        fetchPcModel = redirect_pc;
      end
      if (imem_req && imem_gnt) begin
        check("imem_addr_sequential", imem_addr, fetchPcModel);
        expQ.push_back(fetchPcModel);
        memQ.push_back('{addr: fetchPcModel,
                         due: cyc + $urandom_range(latMax, latMin),
                         stale: 1'b0});
        fetchPcModel += 32'd4;
        acceptCount++;
      end
      if (imem_rvalid) begin
        check("rvalid_has_outstanding", (memQ.size() != 0), 1'b1);
        if (memQ.size() != 0) begin
          if (!memQ[0].stale) begin
            check("push_not_full", (fifoCount < DEPTH), 1'b1);
            fetchedModel++;
          end
          void'(memQ.pop_front());
        end
      end
    end
    cyc++;
  end

  // Behavioural instruction memory: responses are returned in order, at most
  // one per cycle.
  always @(posedge clk) begin
    #1;
    imem_gnt = ($urandom_range(99, 0) < gntPct);
    if (!rst && memQ.size() != 0 && memQ[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = dataOf(memQ[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  // Monitor: compares the presented head and pops the scoreboard on each dequeue.
  always @(negedge clk) begin
    #1;
    if (!rst && !redirect && inst_valid) begin
      if (expQ.size() == 0) begin
        check("output_with_empty_model", expQ.size(), 1);
      end else begin
        check("head_inst", inst_out, dataOf(expQ[0]));
        check("head_pc4", pc4_out, expQ[0] + 32'd4);
        if (deq_ready) begin
          lastPopPc4  = pc4_out;
          lastPopInst = inst_out;
          popCount++;
          void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic doReset(input logic [31:0] key);
    @(posedge clk); #2;
    rst      = 1'b1;
    redirect = 1'b0;
    dataKey  = key;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic waitPop(input string name, input logic [31:0] target);
    int unsigned p0;
    bit found;
    p0 = popCount;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (popCount > p0) found = 1'b1;
    end
    check({name, "_pop_seen"}, found, 1'b1);
    check({name, "_first_pc4"}, lastPopPc4, target + 32'd4);
    check({name, "_first_inst"}, lastPopInst, dataOf(target));
  endtask

  initial begin
    int firstValid;
    int unsigned a0;
    int unsigned p0;
    bit found;

    // 1: streaming at one instruction per cycle from RESET_PC.
    gntPct = 100; latMin = 1; latMax = 1;
    deq_ready = 1'b1;
    doReset(32'h0);
    check("reset_inst_valid", inst_valid, 1'b0);
    check("reset_inst_out", inst_out, 32'h0);
    check("reset_pc4_out", pc4_out, 32'h0);
    check("reset_imem_addr", imem_addr, RESET_PC);
    firstValid = -1;
    // Cycles after release: cycle 0 is the accept, cycle 1 the response, and
    // the head is valid in cycle 2, the third cycle, i.e. after the 2nd edge.
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      if (inst_valid && firstValid < 0) firstValid = k;
    end
    check("first_valid_edge", firstValid, 2);
    p0 = popCount;
    repeat (20) @(posedge clk);
    #2;
    check("stream_one_per_cycle", popCount - p0, 20);

    // 2: stall. Exactly DEPTH fetches are accepted, then requests stop.
    deq_ready = 1'b0;
    doReset(32'h0);
    a0 = acceptCount;
    repeat (10) @(posedge clk);
    #2;
    check("stall_accepts", acceptCount - a0, DEPTH);
    check("stall_req_low", imem_req, 1'b0);
    check("stall_head_inst", inst_out, dataOf(RESET_PC));
    check("stall_head_pc4", pc4_out, RESET_PC + 32'd4);
    deq_ready = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    check("stall_release_resumes", (acceptCount - a0 > DEPTH), 1'b1);

    // 3: redirect while two requests are in flight with 3-cycle latency.
    latMin = 3; latMax = 3;
    doReset(32'h0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #2;
      if (memQ.size() == 2) found = 1'b1;
    end
    check("two_in_flight", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #2;
    redirect = 1'b0;
    waitPop("redirect_inflight", 32'h100);

    // 4: redirect in the same cycle as a response and a dequeue.
    latMin = 1; latMax = 1;
    doReset(32'h0);
    repeat (6) @(posedge clk);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (imem_rvalid && inst_valid) found = 1'b1;
    end
    check("rvalid_and_valid_seen", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #2;
    redirect = 1'b0;
    check("flush_clears_valid", inst_valid, 1'b0);
    waitPop("redirect_with_rvalid", 32'h200);

`ifdef FETCH_PERF_EN
    // 6: eight empty cycles with deq_ready high count eight bubbles.
    gntPct = 0;
    doReset(32'h0);
    repeat (8) @(posedge clk);
    #2;
    check("perf_bubble_8", perf_bubble, 32'd8);
    check("perf_fetched_none", perf_fetched, 32'd0);
`endif

    // 5: random grant, latency, back-pressure and redirects.
    gntPct = 50; latMin = 1; latMax = 4;
    doReset(32'h5EED_C0DE);
    p0 = popCount;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      deq_ready = ($urandom_range(3, 0) != 0);
      redirect  = ($urandom_range(19, 0) == 0);
      if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0;
      else redirect_pc = {$urandom_range(32'hFFFF, 0), 2'b00} << 2;
    end
    @(posedge clk); #2;
    redirect = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("random_progress", (popCount - p0 > 300), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
